// File: rtl/k_half_adder_if.sv
// Bundle of operand and result signals for the lane-parallel half adder.
// The master side supplies operands and the slave side (the adder) returns results.
interface k_half_adder_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
);
    // One extra state is needed for the all-lanes-carry case; WIDTH=1 still gives 1 bit.
    localparam int CNT_BITS = (WIDTH < 1) ? 1 : $clog2(WIDTH + 1);

    logic                in_valid;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic                out_valid;
    logic [WIDTH-1:0]    sum;
    logic [WIDTH-1:0]    c_out;
    logic [CNT_BITS-1:0] carry_cnt;
    logic [CNT_W-1:0]    op_cnt;

    modport master (
        output in_valid,
        output a,
        output b,
        input  out_valid,
        input  sum,
        input  c_out,
        input  carry_cnt,
        input  op_cnt
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        output out_valid,
        output sum,
        output c_out,
        output carry_cnt,
        output op_cnt
    );
endinterface

// File: rtl/k_half_adder.sv
// Registered lane-parallel half adder. Every lane is independent: sum = a ^ b and
// c_out = a & b, both registered with one cycle of latency behind in_valid.
// Also reports how many lanes produced a carry and a saturating count of
// accepted operations. With WIDTH=1 this is a plain registered half adder.
module k_half_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input logic           clk,
    input logic           rst_n,
    k_half_adder_if.slave bus
);
    localparam int CNT_BITS = (WIDTH < 1) ? 1 : $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] OP_MAX = '1;

    generate
        if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
            $error("k_half_adder: WIDTH must be in 1..64");
        end
        if (CNT_W < 1) begin : g_cnt_check
            $error("k_half_adder: CNT_W must be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0]    carry_vec;
    logic [WIDTH-1:0]    sum_vec;
    logic [CNT_BITS-1:0] carry_pop;
    logic [CNT_W-1:0]    op_next;

    logic                out_valid_q;
    logic [WIDTH-1:0]    sum_q;
    logic [WIDTH-1:0]    c_out_q;
    logic [CNT_BITS-1:0] carry_cnt_q;
    logic [CNT_W-1:0]    op_cnt_q;

    // Per-lane half-adder terms; lanes never interact, so there is no carry chain.
    always_comb begin
        sum_vec   = bus.a ^ bus.b;
        carry_vec = bus.a & bus.b;
    end

    // Count the lanes that generate a carry this cycle.
    always_comb begin
        carry_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            carry_pop = carry_pop + CNT_BITS'(carry_vec[i]);
        end
    end

    // Next operation count, pinned at the all-ones value once it gets there.
    always_comb begin
        op_next = op_cnt_q;
        if (op_cnt_q != OP_MAX) begin
            op_next = op_cnt_q + CNT_W'(1);
        end
    end

    // Valid flag follows in_valid by one cycle; reset drops it immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
        end
    end

    // Result registers load only on an accepted operation, so unqualified
    // (possibly X) operands never reach them and idle cycles hold the last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            c_out_q     <= '0;
            carry_cnt_q <= '0;
        end else if (bus.in_valid) begin
            sum_q       <= sum_vec;
            c_out_q     <= carry_vec;
            carry_cnt_q <= carry_pop;
        end
    end

    // Saturating tally of accepted operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt_q <= '0;
        end else if (bus.in_valid) begin
            op_cnt_q <= op_next;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign bus.carry_cnt = carry_cnt_q;
    assign bus.op_cnt    = op_cnt_q;
endmodule

// File: tb/tb_k_half_adder.sv
// Scoreboard bench for k_half_adder. Three instances cover the single-lane
// half adder, an 8-lane block, and an 8-lane block with a 3-bit counter for
// saturation. Expected results are queued when operands are driven and
// compared one cycle later when the result should be visible.
module tb_k_half_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    k_half_adder_if #(.WIDTH(1), .CNT_W(16)) bus_w1 ();
    k_half_adder_if #(.WIDTH(8), .CNT_W(16)) bus_w8 ();
    k_half_adder_if #(.WIDTH(8), .CNT_W(3))  bus_sat ();

    k_half_adder #(.WIDTH(1), .CNT_W(16)) dut_w1  (.clk(clk), .rst_n(rst_n), .bus(bus_w1.slave));
    k_half_adder #(.WIDTH(8), .CNT_W(16)) dut_w8  (.clk(clk), .rst_n(rst_n), .bus(bus_w8.slave));
    k_half_adder #(.WIDTH(8), .CNT_W(3))  dut_sat (.clk(clk), .rst_n(rst_n), .bus(bus_sat.slave));

    typedef struct {
        logic        vld;
        logic [63:0] sum;
        logic [63:0] c_out;
        logic [63:0] cnt;
        logic [63:0] op;
    } exp_t;

    exp_t sb_q[$];

    int errors = 0;
    int checks = 0;

    int unsigned lane_w [3] = '{1, 8, 8};
    logic [63:0] op_max [3] = '{64'd65535, 64'd65535, 64'd7};

    logic [63:0] m_sum  [3];
    logic [63:0] m_cout [3];
    logic [63:0] m_cnt  [3];
    logic [63:0] m_op   [3];

    task automatic resetModel();
        for (int i = 0; i < 3; i++) begin
            m_sum[i]  = '0;
            m_cout[i] = '0;
            m_cnt[i]  = '0;
            m_op[i]   = '0;
        end
        sb_q.delete();
    endtask

    task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic readDut(input int sel, output logic ov, output logic [63:0] os,
                           output logic [63:0] oc, output logic [63:0] ocnt, output logic [63:0] oop);
        case (sel)
            0: begin
                ov   = bus_w1.out_valid;
                os   = 64'(bus_w1.sum);
                oc   = 64'(bus_w1.c_out);
                ocnt = 64'(bus_w1.carry_cnt);
                oop  = 64'(bus_w1.op_cnt);
            end
            1: begin
                ov   = bus_w8.out_valid;
                os   = 64'(bus_w8.sum);
                oc   = 64'(bus_w8.c_out);
                ocnt = 64'(bus_w8.carry_cnt);
                oop  = 64'(bus_w8.op_cnt);
            end
            default: begin
                ov   = bus_sat.out_valid;
                os   = 64'(bus_sat.sum);
                oc   = 64'(bus_sat.c_out);
                ocnt = 64'(bus_sat.carry_cnt);
                oop  = 64'(bus_sat.op_cnt);
            end
        endcase
    endtask

    task automatic checkResetState(input string tag);
        logic        ov;
        logic [63:0] os, oc, ocnt, oop;
        for (int s = 0; s < 3; s++) begin
            readDut(s, ov, os, oc, ocnt, oop);
            checkValue($sformatf("%s.dut%0d.out_valid", tag, s), 64'(ov), 64'd0);
            checkValue($sformatf("%s.dut%0d.sum", tag, s), os, 64'd0);
            checkValue($sformatf("%s.dut%0d.c_out", tag, s), oc, 64'd0);
            checkValue($sformatf("%s.dut%0d.carry_cnt", tag, s), ocnt, 64'd0);
            checkValue($sformatf("%s.dut%0d.op_cnt", tag, s), oop, 64'd0);
        end
    endtask

    task automatic checkOutput(input int sel, input string tag);
        exp_t        e;
        logic        ov;
        logic [63:0] os, oc, ocnt, oop;
        checks++;
        assert (sb_q.size() != 0) else begin
            errors++;
            $error("[TB] FAIL %s.scoreboard observed=empty expected=entry", tag);
        end
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        readDut(sel, ov, os, oc, ocnt, oop);
        checkValue({tag, ".out_valid"}, 64'(ov), 64'(e.vld));
        checkValue({tag, ".sum"}, os, e.sum);
        checkValue({tag, ".c_out"}, oc, e.c_out);
        checkValue({tag, ".carry_cnt"}, ocnt, e.cnt);
        checkValue({tag, ".op_cnt"}, oop, e.op);
        checkValue({tag, ".lane_disjoint"}, os & oc, 64'd0);
    endtask

    task automatic applyStimulus(input int sel, input logic vld, input logic [63:0] a,
                                 input logic [63:0] b, input string tag);
        exp_t        e;
        logic [63:0] mask;
        @(negedge clk);
        bus_w1.in_valid  = 1'b0;
        bus_w8.in_valid  = 1'b0;
        bus_sat.in_valid = 1'b0;
        case (sel)
            0: begin
                bus_w1.in_valid = vld;
                bus_w1.a        = a[0:0];
                bus_w1.b        = b[0:0];
            end
            1: begin
                bus_w8.in_valid = vld;
                bus_w8.a        = a[7:0];
                bus_w8.b        = b[7:0];
            end
            default: begin
                bus_sat.in_valid = vld;
                bus_sat.a        = a[7:0];
                bus_sat.b        = b[7:0];
            end
        endcase
        mask = (64'd1 << lane_w[sel]) - 64'd1;
        if (vld) begin
            m_sum[sel]  = (a ^ b) & mask;
            m_cout[sel] = (a & b) & mask;
            m_cnt[sel]  = 64'($countones(m_cout[sel]));
            if (m_op[sel] != op_max[sel]) begin
                m_op[sel] = m_op[sel] + 64'd1;
            end
        end
        e.vld   = vld;
        e.sum   = m_sum[sel];
        e.c_out = m_cout[sel];
        e.cnt   = m_cnt[sel];
        e.op    = m_op[sel];
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        checkOutput(sel, tag);
    endtask

    initial begin
        bus_w1.in_valid  = 1'b0;
        bus_w1.a         = '0;
        bus_w1.b         = '0;
        bus_w8.in_valid  = 1'b0;
        bus_w8.a         = '0;
        bus_w8.b         = '0;
        bus_sat.in_valid = 1'b0;
        bus_sat.a        = '0;
        bus_sat.b        = '0;
        resetModel();

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetState("por");
        rst_n = 1'b1;

        $display("[TB] single-lane truth table");
        applyStimulus(0, 1'b1, 64'd0, 64'd0, "w1_00_first_edge");
        applyStimulus(0, 1'b1, 64'd0, 64'd1, "w1_01");
        applyStimulus(0, 1'b1, 64'd1, 64'd0, "w1_10");
        applyStimulus(0, 1'b1, 64'd1, 64'd1, "w1_11");
        applyStimulus(0, 1'b0, 'x, 'x, "w1_idle_hold");

        $display("[TB] eight-lane patterns and valid gating");
        applyStimulus(1, 1'b1, 64'hF0, 64'hCC, "w8_f0_cc");
        applyStimulus(1, 1'b1, 64'hFF, 64'hFF, "w8_ff_ff");
        applyStimulus(1, 1'b1, 64'h5A, 64'h0F, "w8_gate_first");
        applyStimulus(1, 1'b0, 'x, 'x, "w8_gate_gap_x");
        applyStimulus(1, 1'b1, 64'h33, 64'h55, "w8_gate_second");
        applyStimulus(1, 1'b0, 'x, 'x, "w8_gate_tail_x");

        $display("[TB] counter saturation");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(2, 1'b1, 64'($urandom), 64'($urandom), $sformatf("sat_%0d", i));
        end
        applyStimulus(2, 1'b0, 'x, 'x, "sat_idle_hold");

        $display("[TB] asynchronous reset mid-operation");
        applyStimulus(1, 1'b1, 64'hA5, 64'h3C, "w8_before_reset");
        #2;
        bus_w1.in_valid  = 1'b0;
        bus_w8.in_valid  = 1'b0;
        bus_sat.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkResetState("async_reset");
        resetModel();
        rst_n = 1'b1;
        applyStimulus(1, 1'b0, 'x, 'x, "w8_hold_after_reset");
        applyStimulus(1, 1'b1, 64'h0F, 64'hFF, "w8_first_accept_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
